// File: rtl/bcd_to_bin_converter_if.sv
// Request/result bundle for the BCD-to-binary converter.
//   start   : conversion request, sampled in IDLE or DONE
//   bcd_in  : packed BCD digits, digit 0 (ones) in bits [3:0]
//   bin_out : converted binary value, held until the next completion
//   busy    : high while a conversion is running
//   done    : one-cycle completion pulse, bin_out/err valid
//   err     : input contained a digit above 9
interface bcd_to_bin_converter_if #(
  parameter int unsigned NDIG = 3,
  parameter int unsigned BW   = 10
);
  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic [BW-1:0]     bin_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter using a reverse double-dabble:
// shift {bcd, bin} right once per cycle, then subtract 3 from every BCD
// digit that reached 8 or more. After BW iterations the bin field holds
// the result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_to_bin_converter_if (start/bcd_in in,
//           bin_out/busy/done/err out, all outputs registered)
module bcd_to_bin_converter #(
  parameter int unsigned NDIG = 3,
  parameter int unsigned BW   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_to_bin_converter_if.slave  bus
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned SW = DW + BW;
  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [SW-1:0]   sr_sh_c;
  logic            bad_c;

  // Any input digit outside 0..9 makes the request invalid.
  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct each digit.
  always_comb begin
    sr_sh_c = {1'b0, sr_q[SW-1:1]};
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (sr_sh_c[BW+4*i +: 4] >= 4'd8)
        sr_sh_c[BW+4*i +: 4] = sr_sh_c[BW+4*i +: 4] - 4'd3;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bad_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            state_d = CONV;
            sr_d    = {bus.bcd_in, BW'(0)};
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      CONV: begin
        sr_d   = sr_sh_c;
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(BW - 1)) begin
          bin_d   = sr_sh_c[BW-1:0];
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Directed bench for bcd_to_bin_converter with a result scoreboard.
module tb_bcd_to_bin_converter;

  localparam int unsigned NDIG = 3;
  localparam int unsigned BW   = 10;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   k_cyc = 0;
  exp_t sbq[$];

  bcd_to_bin_converter_if #(.NDIG(NDIG), .BW(BW)) bus ();

  bcd_to_bin_converter #(.NDIG(NDIG), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always begin
    @(posedge clk);
    #2;
    if (bus.done === 1'b1) begin
      chk("sb_expected_pending", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_bin_out", 32'(bus.bin_out), 32'(e.bin));
        chk("sb_err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one start request across a single edge; records the accept edge.
  task automatic do_start(input logic [11:0] bcd, input logic push,
                          input logic [BW-1:0] eb, input logic ee);
    exp_t e;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    if (push) begin
      e.bin = eb;
      e.err = ee;
      sbq.push_back(e);
    end
    step();
    k_cyc = cyc;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until done is seen; returns edges since the accept edge
  // and the number of sampled cycles with busy high along the way.
  task automatic wait_done(output int lat, output int nbusy);
    int n;
    n = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) nbusy++;
      step();
      n++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
    lat = cyc - k_cyc;
  endtask

  task automatic conv(input string tag, input logic [11:0] bcd,
                      input logic [BW-1:0] eb, input logic ee,
                      input int exp_lat, input int exp_busy);
    int lat, nb;
    do_start(bcd, 1'b1, eb, ee);
    wait_done(lat, nb);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    step();
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, nb;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    #1;
    chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    conv("c999", 12'h999, 10'd999, 1'b0, 10, 10);
    chk("c999_hold", 32'(bus.bin_out), 32'd999);
    conv("c000", 12'h000, 10'd0, 1'b0, 10, 10);
    conv("c255", 12'h255, 10'd255, 1'b0, 10, 10);
    conv("c001", 12'h001, 10'd1, 1'b0, 10, 10);

    // Invalid tens digit: immediate error completion, no busy.
    conv("c7a2", 12'h7A2, 10'd0, 1'b1, 0, 0);
    chk("c7a2_bin", 32'(bus.bin_out), 32'd0);
    chk("c7a2_err_held", 32'(bus.err), 32'd1);
    do_start(12'h042, 1'b1, 10'd42, 1'b0);
    chk("c042_err_cleared", 32'(bus.err), 32'd0);
    chk("c042_busy", 32'(bus.busy), 32'd1);
    wait_done(lat, nb);
    chk("c042_latency", 32'(lat), 32'd10);
    step();

    // Start during CONV must be ignored.
    do_start(12'h123, 1'b1, 10'd123, 1'b0);
    step();
    step();
    step();
    bus.start  = 1'b1;
    bus.bcd_in = 12'h999;
    step();
    bus.start = 1'b0;
    wait_done(lat, nb);
    chk("c123_latency", 32'(lat), 32'd10);
    for (int i = 0; i < 14; i++) step();
    chk("c123_no_extra_done", 32'(sbq.size()), 32'd0);
    chk("c123_idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back: start held through DONE.
    do_start(12'h500, 1'b1, 10'd500, 1'b0);
    bus.start = 1'b1;
    wait_done(lat, nb);
    chk("c500_latency", 32'(lat), 32'd10);
    do_start(12'h321, 1'b1, 10'd321, 1'b0);
    chk("b2b_busy_no_gap", 32'(bus.busy), 32'd1);
    chk("b2b_done_low", 32'(bus.done), 32'd0);
    chk("b2b_bin_held", 32'(bus.bin_out), 32'd500);
    wait_done(lat, nb);
    chk("c321_latency", 32'(lat), 32'd10);
    step();

    // Asynchronous reset mid-conversion aborts without a done pulse.
    do_start(12'h888, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("c888_busy_before_rst", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bin_out", 32'(bus.bin_out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("arst_no_done", 32'(sbq.size()), 32'd0);
    conv("c010", 12'h010, 10'd10, 1'b0, 10, 10);
    chk("c010_hold", 32'(bus.bin_out), 32'd10);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_converter.md
Name: bcd_to_bin_converter

Overview:
- Sequential BCD-to-binary converter; the inverse of the combinational binary-to-BCD path that feeds the seven-segment display.
- Accepts packed BCD digits (hundreds/tens/ones by default) with a start strobe.
- Runs a reverse double-dabble (shift right, subtract 3) over BW clock cycles.
- Returns the binary value with a one-cycle done pulse. Used to turn keypad/BCD operands back into binary for the multiplier datapath.

Parameters:
- NDIG, 3, number of BCD digits; digit 0 = ones at bcd_in[3:0].
- BW, 10, binary output width and iteration count; must satisfy 10^NDIG-1 < 2^BW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- bcd_in  input  4*NDIG  packed BCD digits; sampled only on the edge that accepts start.
- bin_out  output  BW  converted value; registered and held until the next completion.
- busy  output  1  high while in CONV.
- done  output  1  one-cycle pulse: result/err valid.
- err  output  1  high with done when any input digit >9; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bin_out=0, busy=0, done=0, err=0.
  - Internal shift register and iteration counter cleared.
  - Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, CONV, DONE.
- Shift register is {bcd[4*NDIG-1:0], bin[BW-1:0]}; counter 0..BW-1.
- Start acceptance: start=1 on edge k while state is IDLE or DONE.
  - Any digit >9: go to DONE; done=1, err=1, bin_out=0 after edge k; busy stays 0.
  - Otherwise: load bcd=bcd_in, bin=0, cnt=0, err=0; go to CONV; busy=1 after edge k.
- CONV, each edge:
  - Shift the whole register right by 1 (bcd LSB enters bin MSB).
  - Then, for every BCD digit of the shifted value: if digit >=8, subtract 3. This correction is combinational in the same edge.
  - cnt+1.
  - On the edge performing iteration BW (cnt==BW-1):
    - bin_out <= bin field after that shift.
    - state=DONE, done=1, busy=0.
- Latency: done=1 in the cycle after edge k+BW (k+10 at default). Throughput is one conversion per BW+1 cycles.
- DONE lasts exactly one cycle.
  - With start=0: go to IDLE; done=0 after the next edge.
  - With start=1: accepted as from IDLE (back-to-back), no IDLE gap.
- start while busy (CONV): ignored. No queuing, no effect on the running conversion; bcd_in changes during CONV are ignored.
- Output holding:
  - bin_out changes only on successful completion or on an error (set to 0).
  - err clears on the next accepted valid start.
- Arithmetic: digits are unsigned 4-bit; the subtract-3 correction never underflows (applied only when >=8).
- All outputs are driven directly from registers; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with bcd_in=12'h999 -> busy=1 for 10 cycles; done pulse 11 cycles after the start edge; bin_out=10'd999 (0x3E7), err=0.
- bcd_in=12'h000, then 12'h255, then 12'h001 (each waiting for done) -> bin_out=0, 255, 1 respectively; done exactly one cycle each time.
- bcd_in=12'h7A2 (tens digit 0xA) -> done and err high one cycle after the start edge; bin_out=0; busy never asserts. A following valid start of 12'h042 -> err=0, bin_out=42.
- Start 12'h123, then pulse start with 12'h999 at cycle 4 of CONV -> second request ignored; bin_out=123, single done pulse.
- Hold start=1 with 12'h500, then 12'h321 presented in the DONE cycle -> bin_out=500, then the next conversion begins with no IDLE cycle; bin_out=321 eleven cycles later.
- Assert rst_n=0 at CONV cycle 5 of 12'h888 -> all outputs 0 immediately (async); no done after release; a new start of 12'h010 -> bin_out=10.
